vga_sync_decoder: RTL and testbench

//  Sink-side decoder for the 640x480 VGA stream from the breakout video generator. Recovers

---
 rtl/vga_sync_decoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Sink-side 640x480 VGA decoder: pixel X/Y recovery, line/frame timing, lock, errors.
// Optional per-frame CRC-16-CCITT over pixel colours when FRAME_CRC_EN is defined.
module vga_sync_decoder #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRAME    = 800,
  parameter int H_SYNC_LEN = 96,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRAME    = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DrawArea,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  output logic        PixelValid,
  output logic [9:0]  PixelX,
  output logic [8:0]  PixelY,
  output logic [2:0]  PixelRGB,
  output logic [9:0]  LineLen,
  output logic [9:0]  FrameLines,
  output logic        Locked,
  output logic        TimingError,
  output logic        FrameDone,
  output logic [15:0] FrameCRC
);

  localparam logic [9:0] C_HACT_M1 = 10'(H_ACTIVE - 1);
  localparam logic [9:0] C_HFR_M1  = 10'(H_FRAME - 1);
  localparam logic [9:0] C_HSYNC   = 10'(H_SYNC_LEN);
  localparam logic [9:0] C_VACT    = 10'(V_ACTIVE);
  localparam logic [9:0] C_VFR     = 10'(V_FRAME);
  localparam logic [9:0] C_SAT     = 10'h3FF;

  typedef enum logic [1:0] {
    S_SEARCH,
    S_MEASURE,
    S_LOCKED
  } state_t;

  state_t     r_state;
  logic       r_de_d;
  logic       r_hs_d;
  logic       r_vs_d;
  logic       r_hseen;
  logic       r_pass;
  logic [9:0] r_hcnt;
  logic [9:0] r_hwid;
  logic [9:0] r_vcnt;
  logic [9:0] r_acnt;

  logic       w_hs_rise;
  logic       w_hs_fall;
  logic       w_vs_rise;
  logic       w_de_fall;
  logic [9:0] w_lines;
  logic [9:0] w_alines;
  logic       w_line_bad;
  logic       w_hsat;
  logic       w_hwid_bad;
  logic       w_awid_bad;
  logic       w_frame_bad;
  logic       w_fail;

  function automatic logic [9:0] sat_inc(input logic [9:0] v,
                                         input logic en);
    return (en && v != C_SAT) ? v + 10'd1 : v;
  endfunction

  assign w_hs_rise = hSync & ~r_hs_d;
  assign w_hs_fall = ~hSync & r_hs_d;
  assign w_vs_rise = vSync & ~r_vs_d;
  assign w_de_fall = ~DrawArea & r_de_d;

  // A line ending on the same clock as the frame is counted in that frame.
  assign w_lines  = sat_inc(r_vcnt, w_hs_rise);
  assign w_alines = sat_inc(r_acnt, w_de_fall);

  assign w_line_bad  = w_hs_rise & r_hseen & (r_hcnt != C_HFR_M1);
  assign w_hsat      = (r_hcnt == C_SAT);
  assign w_hwid_bad  = w_hs_fall & (r_hwid != C_HSYNC);
  assign w_awid_bad  = w_de_fall & (PixelX != C_HACT_M1);
  assign w_frame_bad = w_vs_rise &
                       ((w_lines != C_VFR) | (w_alines != C_VACT));
  assign w_fail      = w_line_bad | w_hsat | w_hwid_bad |
                       w_awid_bad | w_frame_bad;

  // Previous-cycle copies of the sync inputs for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_de_d <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_de_d <= DrawArea;
      r_hs_d <= hSync;
      r_vs_d <= vSync;
    end
  end

  // Pixel path: one-cycle delayed qualifier/colour with X/Y indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PixelValid <= 1'b0;
      PixelRGB   <= 3'd0;
      PixelX     <= 10'd0;
      PixelY     <= 9'd0;
    end else begin
      PixelValid <= DrawArea;
      PixelRGB   <= {red, green, blue};
      if (DrawArea) begin
        PixelX <= r_de_d ? sat_inc(PixelX, 1'b1) : 10'd0;
      end
      if (w_vs_rise) begin
        PixelY <= 9'd0;
      end else if (w_de_fall && PixelY != 9'h1FF) begin
        PixelY <= PixelY + 9'd1;
      end
    end
  end

  // Line timing: period counter, sync width counter, measured length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt  <= 10'd0;
      r_hseen <= 1'b0;
      r_hwid  <= 10'd0;
      LineLen <= 10'd0;
    end else begin
      if (w_hs_rise) begin
        LineLen <= sat_inc(r_hcnt, 1'b1);
        r_hcnt  <= 10'd0;
        r_hseen <= 1'b1;
      end else begin
        r_hcnt <= sat_inc(r_hcnt, 1'b1);
      end
      if (hSync) begin
        r_hwid <= w_hs_rise ? 10'd1 : sat_inc(r_hwid, 1'b1);
      end
    end
  end

  // Frame timing: lines and active lines per vSync period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vcnt     <= 10'd0;
      r_acnt     <= 10'd0;
      FrameLines <= 10'd0;
      FrameDone  <= 1'b0;
    end else begin
      FrameDone <= w_vs_rise;
      if (w_vs_rise) begin
        FrameLines <= w_lines;
        r_vcnt     <= 10'd0;
        r_acnt     <= 10'd0;
      end else begin
        r_vcnt <= w_lines;
        r_acnt <= w_alines;
      end
    end
  end

  // Lock FSM: one clean measured frame locks, any failure while locked drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_SEARCH;
      r_pass      <= 1'b0;
      Locked      <= 1'b0;
      TimingError <= 1'b0;
    end else begin
      TimingError <= 1'b0;
      unique case (r_state)
        S_SEARCH: begin
          if (w_vs_rise) begin
            r_state <= S_MEASURE;
            r_pass  <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (w_vs_rise) begin
            if (r_pass && !w_fail) begin
              r_state <= S_LOCKED;
              Locked  <= 1'b1;
            end
            r_pass <= 1'b1;
          end else if (w_fail) begin
            r_pass <= 1'b0;
          end
        end
        S_LOCKED: begin
          if (w_fail) begin
            TimingError <= 1'b1;
            Locked      <= 1'b0;
            r_state     <= S_SEARCH;
          end
        end
        default: begin
          r_state <= S_SEARCH;
          Locked  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_nxt;

  function automatic logic [15:0] crc3(input logic [15:0] c,
                                       input logic [2:0] d);
    logic [15:0] v;
    logic        fb;
    v = c;
    for (int i = 2; i >= 0; i--) begin
      fb = v[15] ^ d[i];
      v  = {v[14:0], 1'b0};
      if (fb) v = v ^ 16'h1021;
    end
    return v;
  endfunction

  assign w_crc_nxt = PixelValid ? crc3(r_crc, PixelRGB) : r_crc;

  // Frame CRC accumulator; result latched and restarted on each frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc    <= 16'hFFFF;
      FrameCRC <= 16'h0000;
    end else if (w_vs_rise) begin
      FrameCRC <= w_crc_nxt;
      r_crc    <= 16'hFFFF;
    end else begin
      r_crc <= w_crc_nxt;
    end
  end
`else
  assign FrameCRC = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced raster
// (8 active of 16 clocks per line, 4 active of 6 lines per frame).
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int HF = 16;
  localparam int HS = 3;
  localparam int VA = 4;
  localparam int VF = 6;

  logic        clk;
  logic        reset;
  logic        de;
  logic        hs;
  logic        vs;
  logic        r;
  logic        g;
  logic        b;
  logic        PixelValid;
  logic [9:0]  PixelX;
  logic [8:0]  PixelY;
  logic [2:0]  PixelRGB;
  logic [9:0]  LineLen;
  logic [9:0]  FrameLines;
  logic        Locked;
  logic        TimingError;
  logic        FrameDone;
  logic [15:0] FrameCRC;

  vga_sync_decoder #(
    .H_ACTIVE  (HA),
    .H_FRAME   (HF),
    .H_SYNC_LEN(HS),
    .V_ACTIVE  (VA),
    .V_FRAME   (VF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .DrawArea   (de),
    .hSync      (hs),
    .vSync      (vs),
    .red        (r),
    .green      (g),
    .blue       (b),
    .PixelValid (PixelValid),
    .PixelX     (PixelX),
    .PixelY     (PixelY),
    .PixelRGB   (PixelRGB),
    .LineLen    (LineLen),
    .FrameLines (FrameLines),
    .Locked     (Locked),
    .TimingError(TimingError),
    .FrameDone  (FrameDone),
    .FrameCRC   (FrameCRC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          te_cnt;
  int          fd_cnt;
  int          pv_cnt;
  int          max_px;
  int          max_py;
  int          bad_max_px;
  logic        st_locked;
  logic [9:0]  st_linelen;
  logic [9:0]  st_framelines;
  logic [15:0] st_crc;
  logic        cap_seen;
  logic [2:0]  cap_rgb;
  logic [61:0] rst_vec;
  logic [15:0] exp_crc;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pix(input int x, input int y);
    logic [31:0] ux;
    logic [31:0] uy;
    ux = x;
    uy = y;
    return {ux[0], uy[0], ux[1]};
  endfunction

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic [2:0]  d;
    logic        fb;
    c = 16'hFFFF;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        d = pix(x, y);
        for (int i = 2; i >= 0; i--) begin
          fb = c[15] ^ d[i];
          c  = {c[14:0], 1'b0};
          if (fb) c = c ^ 16'h1021;
        end
      end
    end
    return c;
  endfunction
`endif

  // kind 1: bad_line is one clock longer; kind 2: DrawArea one clock short.
  task automatic drive_frame(input int bad_line, input int kind,
                             input int rst_line);
    int len;
    int dl;
    te_cnt = 0;
    fd_cnt = 0;
    pv_cnt = 0;
    max_px = 0;
    max_py = 0;
    bad_max_px = 0;
    cap_seen = 1'b0;
    cap_rgb = 3'd0;
    for (int ln = 0; ln < VF; ln++) begin
      len = (kind == 1 && ln == bad_line) ? HF + 1 : HF;
      dl  = (kind == 2 && ln == bad_line) ? HA - 1 : HA;
      for (int c = 0; c < len; c++) begin
        hs = (c < HS);
        vs = (ln == 0);
        de = (ln >= 1 && ln <= VA && c >= 4 && c < 4 + dl);
        {r, g, b} = pix(c - 4, ln - 1);
        if (ln == rst_line && c == 6) reset = 1'b1;
        step();
        if (ln == rst_line && c == 6) begin
          rst_vec = {PixelValid, PixelX, PixelY, PixelRGB, LineLen,
                     FrameLines, Locked, TimingError, FrameDone, FrameCRC};
        end
        reset = 1'b0;
        if (ln == 0 && c == 0) begin
          st_locked     = Locked;
          st_linelen    = LineLen;
          st_framelines = FrameLines;
          st_crc        = FrameCRC;
        end
        if (TimingError) te_cnt++;
        if (FrameDone) fd_cnt++;
        if (PixelValid) begin
          pv_cnt++;
          if (int'(PixelX) > max_px) max_px = int'(PixelX);
          if (int'(PixelY) > max_py) max_py = int'(PixelY);
          if (ln == bad_line && int'(PixelX) > bad_max_px)
            bad_max_px = int'(PixelX);
          if (PixelX == 10'd5 && PixelY == 9'd2) begin
            cap_seen = 1'b1;
            cap_rgb  = PixelRGB;
          end
        end
      end
    end
  endtask

  initial begin
`ifdef FRAME_CRC_EN
    exp_crc = model_crc();
`else
    exp_crc = 16'h0000;
`endif
    reset = 1'b1;
    {de, hs, vs, r, g, b} = 6'd0;
    repeat (3) step();
    rst_vec = {PixelValid, PixelX, PixelY, PixelRGB, LineLen,
               FrameLines, Locked, TimingError, FrameDone, FrameCRC};
    check("reset_outputs", 64'(rst_vec), 64'd0);
    reset = 1'b0;
    repeat (2) step();

    drive_frame(-1, 0, -1);
    check("f1_not_locked", 64'(st_locked), 64'd0);

    drive_frame(-1, 0, -1);
    check("f2_locked_at_2nd_vsync", 64'(st_locked), 64'd1);
    check("f2_no_terr", 64'(te_cnt), 64'd0);

    drive_frame(-1, 0, -1);
    check("f3_linelen", 64'(st_linelen), 64'd16);
    check("f3_framelines", 64'(st_framelines), 64'd6);
    check("f3_crc", 64'(st_crc), 64'(exp_crc));
    check("f3_pix_seen", 64'(cap_seen), 64'd1);
    check("f3_pix_5_2_rgb", 64'(cap_rgb), 64'h4);
    check("f3_max_x", 64'(max_px), 64'd7);
    check("f3_max_y", 64'(max_py), 64'd3);
    check("f3_valid_count", 64'(pv_cnt), 64'd32);
    check("f3_framedone_count", 64'(fd_cnt), 64'd1);
    check("f3_still_locked", 64'(Locked), 64'd1);

    drive_frame(3, 1, -1);
    check("f4_crc_repeat", 64'(st_crc), 64'(exp_crc));
    check("f4_long_line_terr", 64'(te_cnt), 64'd1);
    check("f4_unlocked", 64'(Locked), 64'd0);

    drive_frame(-1, 0, -1);
    check("f5_measuring", 64'(st_locked), 64'd0);
    check("f5_no_terr", 64'(te_cnt), 64'd0);

    drive_frame(2, 2, -1);
    check("f6_relocked", 64'(st_locked), 64'd1);
    check("f6_short_de_terr", 64'(te_cnt), 64'd1);
    check("f6_short_line_max_x", 64'(bad_max_px), 64'd6);
    check("f6_unlocked", 64'(Locked), 64'd0);

    drive_frame(-1, 0, -1);
    check("f7_measuring", 64'(st_locked), 64'd0);

    drive_frame(-1, 0, 2);
    check("f8_locked", 64'(st_locked), 64'd1);
    check("f8_midline_reset", 64'(rst_vec), 64'd0);
    check("f8_no_terr", 64'(te_cnt), 64'd0);

    drive_frame(-1, 0, -1);
    check("f9_measuring", 64'(st_locked), 64'd0);

    drive_frame(-1, 0, -1);
    check("f10_relocked", 64'(st_locked), 64'd1);
    check("f10_framelines", 64'(st_framelines), 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
